acc_seq_ctrl: RTL and testbench
===============================

# acc_seq_ctrl

Sequencing controller for the 6-bit accumulator datapath. It accepts one command at a time over a valid/ready handshake (CLR, LOAD, ADD-repeat, SUB-repeat) and holds the 6-bit accumulator register. It drives the operands of the external 6-bit ripple-carry adder and writes the sum back once per cycle for the requested number of iterations. It sits between the command source and the adder, which has no carry-in or carry-out, so the controller handles subtraction and wrap detection itself.

## Interface
- Reset: one clock; reset is synchronous and active-low.
- No parameters; all widths are fixed at 6 bits (data) and 3 bits (count).
- `clk` in 1: sole clock; all state changes on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept; high only in IDLE.
- `cmd_op` in 2: 00 CLR, 01 LOAD, 10 ADD, 11 SUB.
- `cmd_data` in 6: operand (LOAD value / addend / subtrahend).
- `cmd_cnt` in 3: iteration count for ADD/SUB (0–7); ignored for CLR/LOAD.
- `alu_a` out 6: adder operand A, always equal to `acc`.
- `alu_b` out 6: adder operand B, always equal to the latched operand register.
- `alu_y` in 6: adder sum (combinational from `alu_a`/`alu_b`).
- `acc` out 6: accumulator register.
- `wrap` out 1: sticky; set if any iteration of the current command wrapped or borrowed.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, EXEC, DONE.
- Accept happens on a rising edge with IDLE and `cmd_valid`=1 (the same condition as `cmd_valid` && `cmd_ready`). At accept:
  - `wrap` is cleared.
  - Op and count are latched.
  - Operand register is loaded:
    - ADD: `cmd_data`.
    - SUB: (~`cmd_data` + 1) mod 64.
    - CLR/LOAD: 0.
- CLR: `acc` ← 0 at the accept edge; next state DONE.
- LOAD: `acc` ← `cmd_data` at the accept edge; next state DONE.
- ADD/SUB with `cmd_cnt`=0: `acc` is unchanged; next state DONE.
- ADD/SUB with `cmd_cnt`=N>0: next state EXEC, remaining counter ← N.
- EXEC, each cycle:
  - `acc` ← `alu_y`, remaining decrements.
  - When remaining reaches 0 after the write, next state is DONE.
- Arithmetic is mod 64. Wrap detection, evaluated on each EXEC write:
  - ADD sets `wrap` if `alu_y` < `acc` (unsigned).
  - SUB sets `wrap` if `alu_y` > `acc` (unsigned). A subtrahend of 0 yields operand 0, so no borrow.
- DONE: `done`=1 for exactly one cycle, `cmd_ready`=0; next state IDLE.
- `cmd_valid` is ignored outside IDLE. Inputs other than `alu_y` are sampled only at accept, so the command source may change them freely while busy.
- `acc` and `wrap` hold their values in IDLE and DONE.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State IDLE, `acc`=0, operand register=0, remaining=0, `wrap`=0.
  - `done`=0, `busy`=0, `cmd_ready`=1, `alu_a`=0, `alu_b`=0.
- Reset takes priority over everything. Reset during EXEC aborts the command immediately: no `done`, and `acc` is 0 after the edge.
- Accept at edge k gives the following latencies:
  - CLR/LOAD, or ADD/SUB with cnt=0: `done` high during cycle k+1; `cmd_ready` high again from cycle k+2.
  - ADD/SUB with cnt=N: EXEC during cycles k+1..k+N, with `acc` updated at the end of each; `done` during k+N+1; `cmd_ready` from k+N+2.
- Maximum throughput is one command per 2 cycles (CLR/LOAD). Worst case is 9 cycles (cnt=7).
- `alu_y` must settle within one cycle. The controller has no combinational path from `alu_y` to any output.

## Test plan
- Reset, then LOAD 5, then ADD data=3 cnt=4 → `acc`=17, `wrap`=0; `done` 5 cycles after the ADD accept; `cmd_ready` low throughout.
- LOAD 60, ADD data=5 cnt=1 → `acc`=1, `wrap`=1. A following ADD data=1 cnt=1 → `acc`=2, `wrap`=0 (cleared at accept).
- LOAD 3, SUB data=5 cnt=1 → `acc`=62, `wrap`=1. LOAD 10, SUB data=0 cnt=3 → `acc`=10, `wrap`=0, `done` 4 cycles after accept.
- ADD data=7 cnt=0 → `acc` unchanged, `done` the cycle after accept. CLR → `acc`=0, `done` next cycle.
- Hold `cmd_valid`=1 with changing `cmd_data` during EXEC of ADD data=2 cnt=7 from `acc`=0 → intermediate inputs ignored, `acc`=14; the next command is accepted only when `cmd_ready`=1.
- LOAD 20, ADD data=4 cnt=6, assert `rst_n`=0 at the 3rd EXEC cycle → after that edge `acc`=0, state IDLE, `done` never pulses, `cmd_ready`=1.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// Sequencing controller for a 6-bit accumulator around an external adder.
// Runs CLR/LOAD/ADD-repeat/SUB-repeat commands and tracks wrap/borrow.
module acc_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [5:0] cmd_data,
    input  logic [2:0] cmd_cnt,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    input  logic [5:0] alu_y,
    output logic [5:0] acc,
    output logic       wrap,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    state_t     state_r;
    logic [1:0] op_r;
    logic [5:0] opnd_r;
    logic [2:0] rem_r;
    logic [5:0] acc_r;
    logic       wrap_r;
    logic       done_r;
    logic       busy_r;
    logic       ready_r;
    logic [5:0] opnd_nxt_s;
    logic       wrap_hit_s;

    // Two's complement so the adder (no carry-in) can perform subtraction.
    function automatic logic [5:0] negate6(input logic [5:0] v);
        return (~v) + 6'd1;
    endfunction

    // Operand register value chosen at accept time.
    always_comb begin
        opnd_nxt_s = 6'd0;
        case (cmd_op)
            OP_ADD:  opnd_nxt_s = cmd_data;
            OP_SUB:  opnd_nxt_s = negate6(cmd_data);
            default: opnd_nxt_s = 6'd0;
        endcase
    end

    // Wrap/borrow detection on the adder result of the current iteration.
    always_comb begin
        wrap_hit_s = 1'b0;
        if (op_r == OP_SUB) begin
            wrap_hit_s = (alu_y > acc_r);
        end else begin
            wrap_hit_s = (alu_y < acc_r);
        end
    end

    // Command FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= OP_CLR;
            opnd_r  <= 6'd0;
            rem_r   <= 3'd0;
            acc_r   <= 6'd0;
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wrap_r  <= 1'b0;
                        op_r    <= cmd_op;
                        rem_r   <= cmd_cnt;
                        opnd_r  <= opnd_nxt_s;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                        case (cmd_op)
                            OP_CLR: begin
                                acc_r   <= 6'd0;
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                            OP_LOAD: begin
                                acc_r   <= cmd_data;
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                            default: begin
                                if (cmd_cnt == 3'd0) begin
                                    state_r <= ST_DONE;
                                    done_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_EXEC;
                                    done_r  <= 1'b0;
                                end
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    acc_r  <= alu_y;
                    rem_r  <= rem_r - 3'd1;
                    wrap_r <= wrap_r | wrap_hit_s;
                    busy_r  <= 1'b1;
                    ready_r <= 1'b0;
                    // Last iteration: the write above completes the command.
                    if (rem_r <= 3'd1) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_EXEC;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign acc       = acc_r;
    assign alu_a     = acc_r;
    assign alu_b     = opnd_r;
    assign wrap      = wrap_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign cmd_ready = ready_r;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: directed scenarios plus random
// commands checked against an arithmetic model of the accumulator.
module tb_acc_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic [5:0] alu_y;
    logic [5:0] acc;
    logic       wrap;
    logic       done;
    logic       busy;

    int vectors;
    int miscompares;
    int exp_acc;
    bit exp_wrap;
    int exp_lat;
    int exp_opnd;

    acc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .acc(acc), .wrap(wrap), .done(done), .busy(busy)
    );

    // External 6-bit adder without carry in/out.
    assign alu_y = alu_a + alu_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: whole-command effect computed with plain integer math.
    task automatic model_cmd(input logic [1:0] op, input logic [5:0] data, input logic [2:0] cnt);
        int d;
        d = int'(data);
        exp_wrap = 1'b0;
        exp_opnd = 0;
        exp_lat = 1;
        if (op == 2'b00) begin
            exp_acc = 0;
        end else if (op == 2'b01) begin
            exp_acc = d;
        end else begin
            exp_opnd = (op == 2'b10) ? d : (64 - d) % 64;
            exp_lat = int'(cnt) + 1;
            for (int i = 0; i < int'(cnt); i++) begin
                if (op == 2'b10) begin
                    if (exp_acc + d > 63) exp_wrap = 1'b1;
                    exp_acc = (exp_acc + d) % 64;
                end else begin
                    if (exp_acc < d) exp_wrap = 1'b1;
                    exp_acc = ((exp_acc - d) % 64 + 64) % 64;
                end
            end
        end
    endtask

    task automatic scramble_inputs();
        cmd_op   = 2'($urandom_range(0, 3));
        cmd_data = 6'($urandom_range(0, 63));
        cmd_cnt  = 3'($urandom_range(0, 7));
    endtask

    // Issue one command (starting at a negedge) and check it to completion.
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] data, input logic [2:0] cnt, input bit hold);
        int w;
        int lat;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL ready_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        model_cmd(op, data, cnt);
        @(posedge clk);
        @(negedge clk);
        if (hold) scramble_inputs();
        else cmd_valid = 1'b0;
        if (exp_lat > 1) begin
            vectors++;
            if (alu_b !== 6'(exp_opnd)) begin
                miscompares++;
                $display("FAIL alu_b: got %0d required %0d", alu_b, exp_opnd);
            end
        end
        lat = 1;
        while (!done && lat < 12) begin
            vectors++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL exec_status: ready=%0b busy=%0b required 0/1", cmd_ready, busy);
            end
            @(negedge clk);
            lat++;
            if (hold) scramble_inputs();
        end
        vectors++;
        if (lat !== exp_lat || done !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: got %0d (done=%0b) required %0d", lat, done, exp_lat);
        end
        vectors++;
        if (acc !== 6'(exp_acc) || wrap !== exp_wrap || alu_a !== acc) begin
            miscompares++;
            $display("FAIL result: acc=%0d wrap=%0b alu_a=%0d required acc=%0d wrap=%0b",
                     acc, wrap, alu_a, exp_acc, exp_wrap);
        end
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ready: got %0b required 0", cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || acc !== 6'(exp_acc)) begin
            miscompares++;
            $display("FAIL post_done: done=%0b ready=%0b busy=%0b acc=%0d required 0/1/0 acc=%0d",
                     done, cmd_ready, busy, acc, exp_acc);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        scramble_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        vectors++;
        if (acc !== 6'd0 || wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            cmd_ready !== 1'b1 || alu_a !== 6'd0 || alu_b !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_state: acc=%0d wrap=%0b done=%0b busy=%0b ready=%0b alu_a=%0d alu_b=%0d",
                     acc, wrap, done, busy, cmd_ready, alu_a, alu_b);
        end
        exp_acc = 0;
        exp_wrap = 1'b0;
    endtask

    task automatic test_add_basic();
        run_cmd(2'b01, 6'd5, 3'd0, 1'b0);
        run_cmd(2'b10, 6'd3, 3'd4, 1'b0);
        vectors++;
        if (acc !== 6'd17 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL add_basic: acc=%0d wrap=%0b required 17/0", acc, wrap);
        end
    endtask

    task automatic test_wrap();
        run_cmd(2'b01, 6'd60, 3'd0, 1'b0);
        run_cmd(2'b10, 6'd5, 3'd1, 1'b0);
        vectors++;
        if (acc !== 6'd1 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL add_wrap: acc=%0d wrap=%0b required 1/1", acc, wrap);
        end
        run_cmd(2'b10, 6'd1, 3'd1, 1'b0);
        vectors++;
        if (acc !== 6'd2 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_clear: acc=%0d wrap=%0b required 2/0", acc, wrap);
        end
    endtask

    task automatic test_sub();
        run_cmd(2'b01, 6'd3, 3'd0, 1'b0);
        run_cmd(2'b11, 6'd5, 3'd1, 1'b0);
        vectors++;
        if (acc !== 6'd62 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_borrow: acc=%0d wrap=%0b required 62/1", acc, wrap);
        end
        run_cmd(2'b01, 6'd10, 3'd0, 1'b0);
        run_cmd(2'b11, 6'd0, 3'd3, 1'b0);
        vectors++;
        if (acc !== 6'd10 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_zero: acc=%0d wrap=%0b required 10/0", acc, wrap);
        end
    endtask

    task automatic test_cnt0_clr();
        run_cmd(2'b01, 6'd33, 3'd0, 1'b0);
        run_cmd(2'b10, 6'd7, 3'd0, 1'b0);
        vectors++;
        if (acc !== 6'd33) begin
            miscompares++;
            $display("FAIL add_cnt0: acc=%0d required 33", acc);
        end
        run_cmd(2'b00, 6'd45, 3'd5, 1'b0);
        vectors++;
        if (acc !== 6'd0) begin
            miscompares++;
            $display("FAIL clr: acc=%0d required 0", acc);
        end
    endtask

    task automatic test_busy_ignore();
        run_cmd(2'b00, 6'd0, 3'd0, 1'b0);
        run_cmd(2'b10, 6'd2, 3'd7, 1'b1);
        vectors++;
        if (acc !== 6'd14 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore: acc=%0d wrap=%0b required 14/0", acc, wrap);
        end
    endtask

    task automatic test_reset_abort();
        run_cmd(2'b01, 6'd20, 3'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 6'd4;
        cmd_cnt   = 3'd6;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (acc !== 6'd28 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: acc=%0d busy=%0b required 28/1", acc, busy);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (acc !== 6'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || alu_b !== 6'd0) begin
            miscompares++;
            $display("FAIL abort_reset: acc=%0d busy=%0b ready=%0b done=%0b alu_b=%0d required 0/0/1/0/0",
                     acc, busy, cmd_ready, done, alu_b);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || acc !== 6'd0) begin
                miscompares++;
                $display("FAIL abort_quiet: done=%0b acc=%0d required 0/0", done, acc);
            end
        end
        exp_acc = 0;
        exp_wrap = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 6'd0;
        cmd_cnt = 3'd0;
        @(negedge clk);
        test_reset();
        test_add_basic();
        test_wrap();
        test_sub();
        test_cnt0_clr();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
